// File: rtl/dff_scoreboard.sv
// In-order hardware scoreboard: expected values queue in a circular FIFO and each
// observed sample pops the oldest entry, compares it, and updates counters and flags.
module dff_scoreboard #(
   parameter int WIDTH        = 4,
   parameter int DEPTH        = 16,
   parameter int CNT_W        = 16,
   parameter int MAX_MISMATCH = 5
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clear,
   input  logic                       exp_valid,
   input  logic [WIDTH-1:0]           exp_data,
   input  logic                       obs_valid,
   input  logic [WIDTH-1:0]           obs_data,
   output logic [$clog2(DEPTH+1)-1:0] level,
   output logic                       match_pulse,
   output logic                       mismatch_pulse,
   output logic [WIDTH-1:0]           last_exp,
   output logic [WIDTH-1:0]           last_obs,
   output logic [CNT_W-1:0]           matched_cnt,
   output logic [CNT_W-1:0]           mismatched_cnt,
   output logic                       fail,
   output logic                       underflow,
   output logic                       overflow
);

   localparam int LW = $clog2(DEPTH+1);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic {ST_RUN, ST_FAIL} state_t;

   state_t            state, state_next;
   logic [WIDTH-1:0]  mem [DEPTH];
   logic [AW-1:0]     rd_ptr, wr_ptr;

   logic              pop, push, drop, under_ev;
   logic              is_match, is_mis;
   logic [WIDTH-1:0]  head;
   logic [CNT_W-1:0]  mis_next, match_next;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (c == '1) ? c : c + 1'b1;
   endfunction

   // Push/pop qualification; clear masks both ports for the cycle
   always_comb begin
      head       = mem[rd_ptr];
      pop        = obs_valid && !clear && (level != '0);
      under_ev   = obs_valid && !clear && (level == '0);
      push       = exp_valid && !clear && ((level != LW'(DEPTH)) || pop);
      drop       = exp_valid && !clear && !push;
      is_match   = pop && (head == obs_data);
      is_mis     = under_ev || (pop && (head != obs_data));
      match_next = is_match ? sat_inc(matched_cnt)    : matched_cnt;
      mis_next   = is_mis   ? sat_inc(mismatched_cnt) : mismatched_cnt;
   end

   always_comb begin
      state_next = state;
      if (clear)
         state_next = ST_RUN;
      else if ((state == ST_RUN) && is_mis && (mis_next == CNT_W'(MAX_MISMATCH)))
         state_next = ST_FAIL;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= ST_RUN;
      else
         state <= state_next;
   end

   assign fail = (state == ST_FAIL);

   // Storage has no reset: rst_n/clear discard entries by resetting the pointers
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= exp_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         level  <= '0;
      end else if (clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         level  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   // Compare result stage: visible the cycle after obs_valid is sampled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         match_pulse    <= 1'b0;
         mismatch_pulse <= 1'b0;
         last_exp       <= '0;
         last_obs       <= '0;
         matched_cnt    <= '0;
         mismatched_cnt <= '0;
         underflow      <= 1'b0;
         overflow       <= 1'b0;
      end else if (clear) begin
         match_pulse    <= 1'b0;
         mismatch_pulse <= 1'b0;
         last_exp       <= '0;
         last_obs       <= '0;
         matched_cnt    <= '0;
         mismatched_cnt <= '0;
         underflow      <= 1'b0;
         overflow       <= 1'b0;
      end else begin
         match_pulse    <= is_match;
         mismatch_pulse <= is_mis;
         matched_cnt    <= match_next;
         mismatched_cnt <= mis_next;
         if (obs_valid) begin
            last_exp <= pop ? head : '0;
            last_obs <= obs_data;
         end
         if (under_ev)
            underflow <= 1'b1;
         if (drop)
            overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_dff_scoreboard.sv
// Randomized scoreboard bench for dff_scoreboard with a queue-based reference model.
module tb_dff_scoreboard;

   localparam int WIDTH = 4;
   localparam int DEPTH = 16;
   localparam int CNT_W = 16;
   localparam int MAXM  = 5;
   localparam int MAXC  = 65535;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst_n, clear, exp_valid, obs_valid;
   logic [WIDTH-1:0] exp_data, obs_data;
   logic [4:0]       level;
   logic             match_pulse, mismatch_pulse, fail, underflow, overflow;
   logic [WIDTH-1:0] last_exp, last_obs;
   logic [CNT_W-1:0] matched_cnt, mismatched_cnt;

   logic             s_exp_valid, s_obs_valid;
   logic [WIDTH-1:0] s_exp_data, s_obs_data;
   logic [4:0]       s_level;
   logic             s_match_pulse, s_mismatch_pulse, s_fail, s_underflow, s_overflow;
   logic [WIDTH-1:0] s_last_exp, s_last_obs;
   logic [1:0]       s_matched_cnt, s_mismatched_cnt;

   dff_scoreboard #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W), .MAX_MISMATCH(MAXM)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .exp_valid(exp_valid), .exp_data(exp_data),
      .obs_valid(obs_valid), .obs_data(obs_data),
      .level(level), .match_pulse(match_pulse), .mismatch_pulse(mismatch_pulse),
      .last_exp(last_exp), .last_obs(last_obs),
      .matched_cnt(matched_cnt), .mismatched_cnt(mismatched_cnt),
      .fail(fail), .underflow(underflow), .overflow(overflow)
   );

   dff_scoreboard #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(2), .MAX_MISMATCH(3)) dut_sat (
      .clk(clk), .rst_n(rst_n), .clear(1'b0),
      .exp_valid(s_exp_valid), .exp_data(s_exp_data),
      .obs_valid(s_obs_valid), .obs_data(s_obs_data),
      .level(s_level), .match_pulse(s_match_pulse), .mismatch_pulse(s_mismatch_pulse),
      .last_exp(s_last_exp), .last_obs(s_last_obs),
      .matched_cnt(s_matched_cnt), .mismatched_cnt(s_mismatched_cnt),
      .fail(s_fail), .underflow(s_underflow), .overflow(s_overflow)
   );

   typedef struct {
      bit               is_m;
      logic [WIDTH-1:0] e;
      logic [WIDTH-1:0] o;
      int               mc;
      int               mm;
      bit               f;
      int               due;
   } resp_t;

   int               total = 0;
   int               bad = 0;
   int               ncyc = 0;
   logic [WIDTH-1:0] mq[$];
   resp_t            rq[$];
   int               m_mc = 0, m_mm = 0;
   bit               m_fail = 0, m_under = 0, m_over = 0;

   always @(posedge clk) ncyc++;

   task automatic chk(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic int sat(input int v, input int mx);
      return (v < mx) ? v + 1 : v;
   endfunction

   task automatic model_reset();
      mq.delete();
      m_mc = 0; m_mm = 0; m_fail = 0; m_under = 0; m_over = 0;
   endtask

   // One clock of stimulus; the model is updated from the spec rules as it is issued
   task automatic cyc(input bit clr, input bit ev, input logic [WIDTH-1:0] ed,
                      input bit ov, input logic [WIDTH-1:0] od);
      resp_t r;
      clear = clr; exp_valid = ev; exp_data = ed; obs_valid = ov; obs_data = od;
      if (clr) begin
         model_reset();
      end else begin
         if (ov) begin
            if (mq.size() > 0) begin
               r.e = mq.pop_front();
               r.is_m = (r.e == od);
            end else begin
               r.e = '0;
               r.is_m = 0;
               m_under = 1;
            end
            r.o = od;
            if (r.is_m) m_mc = sat(m_mc, MAXC);
            else begin
               m_mm = sat(m_mm, MAXC);
               if (m_mm == MAXM) m_fail = 1;
            end
            r.mc = m_mc; r.mm = m_mm; r.f = m_fail; r.due = ncyc + 1;
            rq.push_back(r);
         end
         if (ev) begin
            if (mq.size() < DEPTH) mq.push_back(ed);
            else m_over = 1;
         end
      end
      @(posedge clk); #1;
      clear = 0; exp_valid = 0; obs_valid = 0;
      chk("level", int'(level), mq.size());
      chk("underflow", int'(underflow), int'(m_under));
      chk("overflow", int'(overflow), int'(m_over));
      chk("fail", int'(fail), int'(m_fail));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, '0, 0, '0);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_level"}, int'(level), 0);
      chk({tag, "_match_pulse"}, int'(match_pulse), 0);
      chk({tag, "_mismatch_pulse"}, int'(mismatch_pulse), 0);
      chk({tag, "_last_exp"}, int'(last_exp), 0);
      chk({tag, "_last_obs"}, int'(last_obs), 0);
      chk({tag, "_matched_cnt"}, int'(matched_cnt), 0);
      chk({tag, "_mismatched_cnt"}, int'(mismatched_cnt), 0);
      chk({tag, "_fail"}, int'(fail), 0);
      chk({tag, "_underflow"}, int'(underflow), 0);
      chk({tag, "_overflow"}, int'(overflow), 0);
   endtask

   // Monitor: every compare result the DUT presents is matched to the oldest expectation
   always @(negedge clk) begin
      resp_t r;
      if (rst_n) begin
         while (rq.size() > 0 && rq[0].due < ncyc) begin
            r = rq.pop_front();
            total++; bad++;
            $display("FAIL missing_pulse actual=none required=compare due at cycle %0d", r.due);
         end
         if (match_pulse || mismatch_pulse) begin
            chk("pulse_exclusive", int'(match_pulse & mismatch_pulse), 0);
            if (rq.size() == 0 || rq[0].due != ncyc) begin
               total++; bad++;
               $display("FAIL unexpected_pulse actual=match%0d/mismatch%0d required=no pulse",
                        match_pulse, mismatch_pulse);
            end else begin
               r = rq.pop_front();
               chk("match_pulse", int'(match_pulse), int'(r.is_m));
               chk("mismatch_pulse", int'(mismatch_pulse), int'(!r.is_m));
               chk("last_exp", int'(last_exp), int'(r.e));
               chk("last_obs", int'(last_obs), int'(r.o));
               chk("matched_cnt", int'(matched_cnt), r.mc);
               chk("mismatched_cnt", int'(mismatched_cnt), r.mm);
               chk("fail_at_compare", int'(fail), int'(r.f));
            end
         end
      end
   end

   initial begin
      logic [WIDTH-1:0] d[5];
      logic [WIDTH-1:0] od;
      bit clr, ev, ov;
      rst_n = 0; clear = 0; exp_valid = 0; obs_valid = 0; exp_data = '0; obs_data = '0;
      s_exp_valid = 0; s_obs_valid = 0; s_exp_data = '0; s_obs_data = '0;
      repeat (2) @(posedge clk);
      #1 check_zero("reset");
      @(negedge clk) rst_n = 1;
      @(posedge clk); #1;

      // ordered match
      cyc(0, 1, 4'h3, 0, '0); cyc(0, 1, 4'h7, 0, '0); cyc(0, 1, 4'hA, 0, '0);
      cyc(0, 0, '0, 1, 4'h3); cyc(0, 0, '0, 1, 4'h7); cyc(0, 0, '0, 1, 4'hA);
      idle(2);
      chk("ordered_matched_cnt", int'(matched_cnt), 3);

      // mismatches drive the block into FAIL
      for (int i = 0; i < 5; i++) begin
         d[i] = 4'($urandom);
         cyc(0, 1, d[i], 0, '0);
      end
      for (int i = 0; i < 5; i++) cyc(0, 0, '0, 1, d[i] ^ 4'h1);
      idle(1);
      chk("fail_after_5", int'(fail), 1);
      chk("last_exp_5th", int'(last_exp), int'(d[4]));
      chk("last_obs_5th", int'(last_obs), int'(d[4] ^ 4'h1));

      // clear while in FAIL with four entries queued
      for (int i = 0; i < 4; i++) cyc(0, 1, 4'($urandom), 0, '0);
      chk("level_before_clear", int'(level), 4);
      cyc(1, 1, 4'h5, 1, 4'h5);
      check_zero("clear");

      // underflow with a same-cycle push: no bypass
      cyc(0, 1, 4'h9, 1, 4'h9);
      idle(1);
      chk("underflow_last_exp", int'(last_exp), 0);
      cyc(0, 0, '0, 1, 4'h9);
      idle(1);
      cyc(1, 0, '0, 0, '0);

      // fill, overflow, push+pop while full, then drain in order
      for (int i = 0; i < DEPTH; i++) cyc(0, 1, 4'($urandom), 0, '0);
      cyc(0, 1, 4'($urandom), 0, '0);
      cyc(0, 1, 4'($urandom), 1, mq[0]);
      for (int i = 0; i < DEPTH; i++) cyc(0, 0, '0, 1, mq[0]);
      idle(1);
      cyc(1, 0, '0, 0, '0);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         clr = ($urandom_range(63) == 0);
         ev  = $urandom_range(1);
         ov  = $urandom_range(1);
         od  = (mq.size() > 0 && $urandom_range(3) != 0) ? mq[0] : 4'($urandom);
         cyc(clr, ev, 4'($urandom), ov, od);
      end
      idle(2);

      // asynchronous reset in the middle of a burst
      cyc(0, 1, 4'h1, 0, '0); cyc(0, 1, 4'h2, 1, mq[0]); cyc(0, 1, 4'h3, 1, mq[0]);
      exp_valid = 1; exp_data = 4'h4; obs_valid = 1; obs_data = 4'h2;
      #3 rst_n = 0;
      #1 check_zero("async_reset");
      exp_valid = 0; obs_valid = 0;
      model_reset();
      rq.delete();
      @(negedge clk) rst_n = 1;
      @(posedge clk); #1;
      cyc(0, 1, 4'hC, 0, '0);
      cyc(0, 0, '0, 1, 4'hC);
      idle(1);
      chk("post_reset_matched", int'(matched_cnt), 1);
      chk("resp_queue_drained", rq.size(), 0);

      // saturating counters on a CNT_W=2 instance
      for (int i = 0; i < 5; i++) begin
         s_exp_valid = 1; s_exp_data = 4'(i + 2);
         @(posedge clk); #1;
      end
      s_exp_valid = 0;
      for (int i = 0; i < 5; i++) begin
         s_obs_valid = 1; s_obs_data = 4'(i + 2);
         @(posedge clk); #1;
      end
      s_obs_valid = 0;
      @(posedge clk); #1;
      chk("sat_matched_cnt", int'(s_matched_cnt), 3);
      chk("sat_mismatched_cnt", int'(s_mismatched_cnt), 0);
      chk("sat_level", int'(s_level), 0);
      chk("sat_fail", int'(s_fail), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
